// File: rtl/alu_sec_banco.sv
// -----------------------------------------------------------------------------
// alu_sec_banco
//
// Moore sequencer for a 2-entry operand register bank feeding an ALU.
// A command (opcode + two operands) is accepted over a valid/ready handshake.
// The controller then:
//   - writes operand A to bank entry 0 and operand B to bank entry 1,
//     or skips both writes when cmd_reuse is set;
//   - issues one bank read so the bank presents both entries to the ALU;
//   - waits ALU_LAT cycles and captures the ALU result and carry.
// The captured result is returned over a second valid/ready handshake.
// This block is the only driver of the bank control pins.
//
// Optional feature (macro WRITEBACK_EN):
//   When defined, the accepted result is written back into bank entry 0 in
//   an extra WB state. A following reuse command then computes result-op-B,
//   which gives accumulator behaviour. When undefined, results never touch
//   the bank.
//
// Parameters:
//   W        operand/result width (must match the bank word width)
//   OPW      ALU opcode width
//   ALU_LAT  cycles from the bank read completing to a valid ALU result.
//            Legal range is 1..15. The wait counter is 4 bits and wraps, so
//            other values do not give the intended latency.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_op, cmd_a, cmd_b     command opcode and operands
//   cmd_reuse                1 = skip bank writes, reuse the stored operands
//   res_valid/res_ready      result handshake
//   res_data, res_carry      captured ALU result and carry/flag
//   busy                     controller is not idle
//   w_r_reg, regadd, wd_reg, bank write(1)/read(0) select, entry address,
//   enable_reg               write data and enable
//   alu_op                   opcode presented to the ALU
//   alu_res, alu_carry       ALU result and carry/flag
// -----------------------------------------------------------------------------
module alu_sec_banco #(
    parameter int unsigned W       = 4,
    parameter int unsigned OPW     = 3,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,

    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [OPW-1:0] cmd_op,
    input  logic [W-1:0]   cmd_a,
    input  logic [W-1:0]   cmd_b,
    input  logic           cmd_reuse,

    output logic           res_valid,
    input  logic           res_ready,
    output logic [W-1:0]   res_data,
    output logic           res_carry,

    output logic           busy,

    output logic           w_r_reg,
    output logic           regadd,
    output logic [W-1:0]   wd_reg,
    output logic           enable_reg,

    output logic [OPW-1:0] alu_op,
    input  logic [W-1:0]   alu_res,
    input  logic           alu_carry
);

    // Value of the wait counter on the edge that captures the ALU result.
    // Truncated to the 4-bit counter width on purpose: out-of-range latencies wrap.
    localparam logic [3:0] LastCnt = 4'(ALU_LAT - 1);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StWrA  = 3'd1,
        StWrB  = 3'd2,
        StRd   = 3'd3,
        StExec = 3'd4,
        StDone = 3'd5
`ifdef WRITEBACK_EN
        ,
        StWb   = 3'd6
`endif
    } state_e;

    state_e         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   res_data_q, res_data_d;
    logic           res_carry_q, res_carry_d;
    logic [3:0]     cnt_q, cnt_d;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_data_q  <= res_data_d;
            res_carry_q <= res_carry_d;
            cnt_q       <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        res_data_d  = res_data_q;
        res_carry_d = res_carry_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            StIdle: begin
                // cmd_ready is 1 throughout IDLE, so cmd_valid alone is the handshake.
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    state_d = cmd_reuse ? StRd : StWrA;
                end
            end

            StWrA: begin
                state_d = StWrB;
            end

            StWrB: begin
                state_d = StRd;
            end

            StRd: begin
                // The bank registers both entries on this edge; the ALU latency
                // is counted from here.
                cnt_d   = '0;
                state_d = StExec;
            end

            StExec: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LastCnt) begin
                    res_data_d  = alu_res;
                    res_carry_d = alu_carry;
                    state_d     = StDone;
                end
            end

            StDone: begin
                if (res_ready) begin
`ifdef WRITEBACK_EN
                    state_d = StWb;
`else
                    state_d = StIdle;
`endif
                end
            end

`ifdef WRITEBACK_EN
            StWb: begin
                state_d = StIdle;
            end
`endif

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Moore outputs: a function of the current state and registered values only
    // -------------------------------------------------------------------------
    always_comb begin
        cmd_ready  = 1'b0;
        res_valid  = 1'b0;
        busy       = 1'b1;
        enable_reg = 1'b0;
        w_r_reg    = 1'b0;
        regadd     = 1'b0;
        wd_reg     = '0;
        alu_op     = op_q;

        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                alu_op    = '0;
            end

            StWrA: begin
                enable_reg = 1'b1;
                w_r_reg    = 1'b1;
                regadd     = 1'b0;
                wd_reg     = a_q;
            end

            StWrB: begin
                enable_reg = 1'b1;
                w_r_reg    = 1'b1;
                regadd     = 1'b1;
                wd_reg     = b_q;
            end

            StRd: begin
                enable_reg = 1'b1;
                w_r_reg    = 1'b0;
            end

            StExec: begin
            end

            StDone: begin
                res_valid = 1'b1;
            end

`ifdef WRITEBACK_EN
            StWb: begin
                // Entry 0 takes the last result so a reuse command accumulates.
                enable_reg = 1'b1;
                w_r_reg    = 1'b1;
                regadd     = 1'b0;
                wd_reg     = res_data_q;
            end
`endif

            default: begin
            end
        endcase
    end

    assign res_data  = res_data_q;
    assign res_carry = res_carry_q;

endmodule

// File: tb/tb_alu_sec_banco.sv
// -----------------------------------------------------------------------------
// tb_alu_sec_banco
//
// Two controllers run side by side, one built with ALU_LAT=1 and one with
// ALU_LAT=3. Each has its own behavioural bank and ALU. Both share the
// command fields, res_ready and rst. Each has its own cmd_valid so that they
// may accept at different edges.
//
// The reference model is transaction level. On accept it updates a model
// bank, computes the expected result, and sets the number of edges until
// res_valid. A single compare process checks every output of both
// controllers on every falling edge against that model. It also checks a few
// hand-computed results and latencies for the first three results.
// -----------------------------------------------------------------------------
module tb_alu_sec_banco;

    localparam int unsigned W   = 4;
    localparam int unsigned OPW = 3;
    localparam int          NL  = 2;

    localparam int PhIdle = 0;
    localparam int PhBusy = 1;
    localparam int PhDone = 2;
    localparam int PhWb   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NL-1:0]  cmd_valid = '0;
    logic [OPW-1:0] cmd_op    = '0;
    logic [W-1:0]   cmd_a     = '0;
    logic [W-1:0]   cmd_b     = '0;
    logic           cmd_reuse = 1'b0;
    logic           res_ready = 1'b0;
    int             rr_mode   = 0;  // 0: hold low, 1: hold high, 2: random
    logic           stall     = 1'b0;

    logic [NL-1:0]  cmd_ready_w, res_valid_w, res_carry_w, busy_w, w_r_w, regadd_w, en_w;
    logic [W-1:0]   res_data_w [NL];
    logic [W-1:0]   wd_w       [NL];
    logic [OPW-1:0] alu_op_w   [NL];

    // Reference ALU: {carry, result}
    function automatic logic [W:0] alu_f(input logic [OPW-1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        case (op)
            3'd0:    return {1'b0, a & b};
            3'd1:    return {1'b0, a} + {1'b0, b};
            3'd2:    return {1'b0, a} - {1'b0, b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            default: return {1'b0, a};
        endcase
    endfunction

    function automatic int lane_lat(input int l);
        return (l == 0) ? 1 : 3;
    endfunction

    // Hand-computed expectations for the first three results.
    function automatic logic [31:0] lit_res(input int n);
        case (n)
            0: return 32'h8;
`ifdef WRITEBACK_EN
            1: return 32'hB;
`else
            1: return 32'h8;
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] lit_lat(input int l, input int n);
        return 32'(((n == 1) ? 1 : 3) + lane_lat(l));
    endfunction

    // -------------------------------------------------------------------------
    // Lanes: bank model, ALU with latency, DUT
    // -------------------------------------------------------------------------
    for (genvar g = 0; g < NL; g++) begin : g_lane
        localparam int unsigned Lat = (g == 0) ? 1 : 3;
        logic [W-1:0] bank [2];
        logic [W-1:0] rd1, rd2;
        logic [W:0]   comb_v;
        logic [W:0]   pipe [15];
        logic [W:0]   alu_o;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                bank[0] <= '0;
                bank[1] <= '0;
                rd1     <= '0;
                rd2     <= '0;
            end else if (en_w[g]) begin
                if (w_r_w[g]) bank[regadd_w[g]] <= wd_w[g];
                else begin
                    rd1 <= bank[0];
                    rd2 <= bank[1];
                end
            end
        end

        assign comb_v = alu_f(alu_op_w[g], rd1, rd2);

        always @(posedge clk) begin
            pipe[0] <= comb_v;
            for (int i = 1; i < 15; i++) pipe[i] <= pipe[i-1];
        end

        assign alu_o = (Lat >= 2) ? pipe[(Lat >= 2) ? Lat - 2 : 0] : comb_v;

        alu_sec_banco #(
            .W      (W),
            .OPW    (OPW),
            .ALU_LAT(Lat)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .cmd_valid (cmd_valid[g]),
            .cmd_ready (cmd_ready_w[g]),
            .cmd_op    (cmd_op),
            .cmd_a     (cmd_a),
            .cmd_b     (cmd_b),
            .cmd_reuse (cmd_reuse),
            .res_valid (res_valid_w[g]),
            .res_ready (res_ready),
            .res_data  (res_data_w[g]),
            .res_carry (res_carry_w[g]),
            .busy      (busy_w[g]),
            .w_r_reg   (w_r_w[g]),
            .regadd    (regadd_w[g]),
            .wd_reg    (wd_w[g]),
            .enable_reg(en_w[g]),
            .alu_op    (alu_op_w[g]),
            .alu_res   (alu_o[W-1:0]),
            .alu_carry (alu_o[W])
        );
    end

    // -------------------------------------------------------------------------
    // Reference model and compare process
    // -------------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    int             ph      [NL];
    int             cnt     [NL];
    int             tlat    [NL];
    int             n_res   [NL] = '{0, 0};
    logic           fresh   [NL];
    logic           m_full  [NL];
    logic [OPW-1:0] m_op    [NL];
    logic [W-1:0]   m_a     [NL];
    logic [W-1:0]   m_b     [NL];
    logic [W-1:0]   m_bank0 [NL];
    logic [W-1:0]   m_bank1 [NL];
    logic [W-1:0]   m_res   [NL];
    logic           m_car   [NL];
    logic [W-1:0]   m_hold  [NL];
    logic           m_hold_c[NL];

    logic           e_en, e_wr, e_ad;
    logic [W-1:0]   e_wd;
    int             k;

    task automatic chk(input string name, input int l, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s lane%0d t=%0t: got %0h expected %0h", name, l, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("no_stall", 0, 32'(stall), 32'd0);
        for (int l = 0; l < NL; l++) begin
            if (rst) begin
                ph[l]       = PhIdle;
                cnt[l]      = 0;
                fresh[l]    = 1'b0;
                m_op[l]     = '0;
                m_bank0[l]  = '0;
                m_bank1[l]  = '0;
                m_hold[l]   = '0;
                m_hold_c[l] = 1'b0;
            end

            // Expected bank pins, from the command schedule: writes A, B, then read.
            e_en = 1'b0;
            e_wr = 1'b0;
            e_ad = 1'b0;
            e_wd = '0;
            if (ph[l] == PhBusy) begin
                k = m_full[l] ? cnt[l] : cnt[l] + 2;
                case (k)
                    0: begin e_en = 1'b1; e_wr = 1'b1; e_wd = m_a[l]; end
                    1: begin e_en = 1'b1; e_wr = 1'b1; e_ad = 1'b1; e_wd = m_b[l]; end
                    2: e_en = 1'b1;
                    default: ;
                endcase
            end else if (ph[l] == PhWb) begin
                e_en = 1'b1;
                e_wr = 1'b1;
                e_wd = m_hold[l];
            end

            chk("cmd_ready", l, 32'(cmd_ready_w[l]), 32'(ph[l] == PhIdle));
            chk("busy", l, 32'(busy_w[l]), 32'(ph[l] != PhIdle));
            chk("res_valid", l, 32'(res_valid_w[l]), 32'(ph[l] == PhDone));
            chk("res_data", l, 32'(res_data_w[l]), 32'(m_hold[l]));
            chk("res_carry", l, 32'(res_carry_w[l]), 32'(m_hold_c[l]));
            chk("enable_reg", l, 32'(en_w[l]), 32'(e_en));
            chk("w_r_reg", l, 32'(w_r_w[l]), 32'(e_wr));
            chk("regadd", l, 32'(regadd_w[l]), 32'(e_ad));
            chk("wd_reg", l, 32'(wd_w[l]), 32'(e_wd));
            chk("alu_op", l, 32'(alu_op_w[l]), (ph[l] == PhIdle) ? 32'd0 : 32'(m_op[l]));

            if (fresh[l] && n_res[l] < 3) begin
                chk("lit_res", l, 32'(res_data_w[l]), lit_res(n_res[l]));
                chk("lit_carry", l, 32'(res_carry_w[l]), 32'(n_res[l] == 2));
                chk("lit_latency", l, 32'(cnt[l]), lit_lat(l, n_res[l]));
            end

            // Advance the model to the state after the coming rising edge.
            if (!rst) begin
                case (ph[l])
                    PhIdle: begin
                        if (cmd_valid[l]) begin
                            m_op[l]   = cmd_op;
                            m_a[l]    = cmd_a;
                            m_b[l]    = cmd_b;
                            m_full[l] = !cmd_reuse;
                            if (!cmd_reuse) begin
                                m_bank0[l] = cmd_a;
                                m_bank1[l] = cmd_b;
                            end
                            {m_car[l], m_res[l]} = alu_f(cmd_op, m_bank0[l], m_bank1[l]);
                            tlat[l] = (cmd_reuse ? 1 : 3) + lane_lat(l);
                            cnt[l]  = 0;
                            ph[l]   = PhBusy;
                        end
                    end
                    PhBusy: begin
                        cnt[l]++;
                        if (cnt[l] == tlat[l]) begin
                            ph[l]       = PhDone;
                            m_hold[l]   = m_res[l];
                            m_hold_c[l] = m_car[l];
                            fresh[l]    = 1'b1;
                        end
                    end
                    PhDone: begin
                        fresh[l] = 1'b0;
                        if (res_ready) begin
                            n_res[l]++;
`ifdef WRITEBACK_EN
                            ph[l]      = PhWb;
                            m_bank0[l] = m_hold[l];
`else
                            ph[l]      = PhIdle;
`endif
                        end
                    end
                    default: ph[l] = PhIdle;
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    always begin
        @(posedge clk);
        #2;
        case (rr_mode)
            0:       res_ready = 1'b0;
            1:       res_ready = 1'b1;
            default: res_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    task automatic wait_accept();
        logic [NL-1:0] acc;
        int t;
        t = 0;
        while (cmd_valid != '0 && t < 300) begin
            @(negedge clk);
            acc = cmd_valid & cmd_ready_w;
            @(posedge clk);
            #1;
            cmd_valid = cmd_valid & ~acc;
            t++;
        end
        if (cmd_valid != '0) begin
            stall     = 1'b1;
            cmd_valid = '0;
        end
    endtask

    task automatic issue(input logic [OPW-1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic reuse);
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_reuse = reuse;
        cmd_valid = '1;
        wait_accept();
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (busy_w != '0 && t < 500);
        if (busy_w != '0) stall = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rr_mode = 1;
        @(posedge clk);
        #1;

        // Reset while in WR_B: command abandoned, bank cleared.
        issue(3'b001, 4'h5, 4'h3, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        wait_idle();

        // Directed: full load, reuse, overflow.
        issue(3'b001, 4'h5, 4'h3, 1'b0);
        wait_idle();
        issue(3'b001, 4'hA, 4'hA, 1'b1);
        wait_idle();
        issue(3'b001, 4'hF, 4'h1, 1'b0);
        wait_idle();

        // Backpressure: result held, a command waits behind it.
        rr_mode = 0;
        issue(3'b001, 4'h2, 4'h2, 1'b0);
        for (int t = 0; t < 100 && res_valid_w != '1; t++) @(negedge clk);
        if (res_valid_w != '1) stall = 1'b1;
        @(posedge clk);
        #1;
        cmd_op    = 3'b010;
        cmd_a     = 4'h7;
        cmd_b     = 4'h1;
        cmd_reuse = 1'b0;
        cmd_valid = '1;
        repeat (5) @(posedge clk);
        #1 rr_mode = 1;
        wait_accept();
        wait_idle();

        // Randomized traffic with random result backpressure.
        rr_mode = 2;
        for (int n = 0; n < 60; n++) begin
            issue(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom),
                  ($urandom_range(0, 3) == 0));
            if (n == 30) begin
                @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
            end
            if ($urandom_range(0, 1) == 0) wait_idle();
        end
        rr_mode = 1;
        wait_idle();
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sec_banco.md
Name: alu_sec_banco

Overview:
- Moore FSM controller that sequences the 2-entry operand register bank and the ALU.
- Accepts a command (opcode plus two operands) over a valid/ready handshake, then:
  - writes operand A to bank entry 0 and operand B to bank entry 1,
  - issues a bank read so the bank presents both entries to the ALU,
  - waits out the ALU latency and captures the result.
- Returns the result over a second valid/ready handshake.
- Sits between the command source (top-level/user logic) and the bank+ALU datapath; it is the only driver of the bank control pins.

Parameters:
- W, 4, operand/result data width; must match the bank word width.
- OPW, 3, ALU opcode width.
- ALU_LAT, 1, cycles from the bank read completing to the ALU result being valid; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  OPW  ALU opcode
- cmd_a  in  W  operand A
- cmd_b  in  W  operand B
- cmd_reuse  in  1  1 = skip bank writes and reuse the operands already stored
- res_valid  out  1  result held and valid
- res_ready  in  1  consumer takes the result
- res_data  out  W  captured ALU result
- res_carry  out  1  captured ALU carry/flag
- busy  out  1  controller is not in IDLE
- w_r_reg  out  1  bank write(1)/read(0) select
- regadd  out  1  bank entry address
- wd_reg  out  W  bank write data
- enable_reg  out  1  bank enable
- alu_op  out  OPW  opcode to the ALU
- alu_res  in  W  ALU result
- alu_carry  in  1  ALU carry/flag

Behaviour:
- States: IDLE, WR_A, WR_B, RD, EXEC, DONE, plus WB when WRITEBACK_EN is defined.
- Reset (rst high, asynchronous): state=IDLE; all registered values cleared (op, a, b, res_data, res_carry, wait counter); every output 0 except cmd_ready, which is 1 because the state is IDLE.
- Reset mid-operation: any in-flight command is abandoned and nothing further is written to the bank. The bank shares rst, so a later reuse command operates on 0/0.
- IDLE:
  - cmd_ready=1.
  - On an edge with cmd_valid&cmd_ready, latch op, a and b.
  - Next state is RD if cmd_reuse=1, otherwise WR_A.
- WR_A: enable_reg=1, w_r_reg=1, regadd=0, wd_reg=a. Next state WR_B.
- WR_B: enable_reg=1, w_r_reg=1, regadd=1, wd_reg=b. Next state RD.
- RD: enable_reg=1, w_r_reg=0. The bank registers rd_reg1/rd_reg2 on this edge. Next state EXEC, counter=0.
- EXEC:
  - alu_op=op; the counter increments every cycle.
  - On the edge where counter==ALU_LAT-1: res_data<=alu_res, res_carry<=alu_carry, next state DONE.
- DONE:
  - res_valid=1; res_data and res_carry held stable.
  - On an edge with res_ready=1, go to IDLE (or WB when the macro is defined).
  - If res_ready stays low, hold DONE indefinitely.
- In all states other than those listed: enable_reg=0, w_r_reg=0, regadd=0, wd_reg=0. alu_op=op outside IDLE, 0 in IDLE.
- busy = (state != IDLE).
- cmd_ready is 0 outside IDLE. A cmd_valid arriving while busy is not accepted and must be held by the source.
- Latency, counted from the accepting edge to res_valid rising:
  - 3+ALU_LAT edges for a full load.
  - 1+ALU_LAT edges for a reuse command.
- A result is accepted and a new command is accepted no sooner than one cycle apart: DONE→IDLE→accept, no same-cycle bypass.
- Out-of-range ALU_LAT is a configuration error: the counter is 4 bits and wraps.

Optional Feature:
- Macro WRITEBACK_EN, accumulator write-back.
- Defined:
  - DONE&res_ready goes to WB.
  - WB: enable_reg=1, w_r_reg=1, regadd=0, wd_reg=res_data, then IDLE. Bank entry 0 then holds the last result, so a reuse command computes result-op-B.
  - cmd_ready=0 and busy=1 during WB.
- Not defined: no WB state; DONE&res_ready goes directly to IDLE; bank contents are unchanged by results.

Test Plan:
- Reset: assert rst mid-WR_B, release → cmd_ready=1, res_valid=0, enable_reg=0, busy=0, res_data=0; no further bank write occurs.
- Full load, ALU_LAT=1, op=3'b001, a=4'h5, b=4'h3, model ALU returns 4'h8/carry 0, res_ready=1:
  - pins per state: WR_A regadd=0 wd=5; WR_B regadd=1 wd=3; RD w_r=0.
  - res_valid rises 4 edges after accept with res_data=8.
- Overflow with ALU_LAT=3: a=4'hF, b=4'h1, ALU returns 0/carry 1 → res_valid 6 edges after accept, res_data=0, res_carry=1.
- Reuse after a full load of a=4'h5, b=4'h3: cmd_reuse=1 with cmd_a=cmd_b=4'hA → no bank writes; ALU sees bank values 5 and 3; res_valid 2 edges after accept (ALU_LAT=1).
- Backpressure: hold res_ready=0 for 5 cycles → DONE held, res_data stable, cmd_ready=0 throughout, and a cmd_valid issued meanwhile is not accepted until one cycle after res_ready.
- WRITEBACK_EN: first result 4'h8, then a reuse add with b=4'h3 → a WB write of entry 0 with 8 is observed; second result is 4'hB.
